// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser: coin codes, coin values and
// the sequencer state encoding.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NICKEL  = 2'd0,
    COIN_DIME    = 2'd1,
    COIN_QUARTER = 2'd2,
    COIN_DOLLAR  = 2'd3
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_FINISH
  } state_e;

  localparam logic [6:0] VAL_NICKEL  = 7'd5;
  localparam logic [6:0] VAL_DIME    = 7'd10;
  localparam logic [6:0] VAL_QUARTER = 7'd25;
  localparam logic [6:0] VAL_DOLLAR  = 7'd100;

  function automatic logic [6:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_NICKEL:  return VAL_NICKEL;
      COIN_DIME:    return VAL_DIME;
      COIN_QUARTER: return VAL_QUARTER;
      default:      return VAL_DOLLAR;
    endcase
  endfunction

endpackage

// File: rtl/vend_coin_inventory.sv
// Hopper inventory: four saturating per-denomination counters.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset (loads INIT_*)
//   i_refill_valid/coin/count  add coins to one tube
//   i_dec_valid/coin        one coin of that tube has left the hopper
//   o_inv                   current counts, index = coin code
//   o_nonzero               per-coin "tube not empty" flags for selection
module vend_coin_inventory
  import vend_pkg::*;
#(
  parameter int INV_W        = 6,
  parameter int INIT_NICKEL  = 20,
  parameter int INIT_DIME    = 20,
  parameter int INIT_QUARTER = 20,
  parameter int INIT_DOLLAR  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_refill_valid,
  input  logic [1:0]            i_refill_coin,
  input  logic [INV_W-1:0]      i_refill_count,
  input  logic                  i_dec_valid,
  input  logic [1:0]            i_dec_coin,
  output logic [3:0][INV_W-1:0] o_inv,
  output logic [3:0]            o_nonzero
);

  localparam logic [INV_W:0] INV_MAX = {1'b0, {INV_W{1'b1}}};

  logic [3:0][INV_W-1:0] r_inv;
  logic [3:0][INV_W-1:0] w_inv_nxt;
  logic [3:0][INV_W:0]   w_sum;

  // Decrement is applied before the refill add so that a simultaneous
  // refill and eject of the same coin saturates on (inv - 1 + count).
  always_comb begin
    w_sum     = '0;
    w_inv_nxt = r_inv;
    o_nonzero = '0;
    for (int i = 0; i < 4; i++) begin
      o_nonzero[i] = |r_inv[i];
      w_sum[i] = {1'b0, r_inv[i]};
      if (i_dec_valid && i_dec_coin == 2'(i) && o_nonzero[i])
        w_sum[i] = w_sum[i] - (INV_W+1)'(1);
      if (i_refill_valid && i_refill_coin == 2'(i))
        w_sum[i] = w_sum[i] + {1'b0, i_refill_count};
      w_inv_nxt[i] = (w_sum[i] > INV_MAX) ? {INV_W{1'b1}} : w_sum[i][INV_W-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inv[COIN_NICKEL]  <= INV_W'(INIT_NICKEL);
      r_inv[COIN_DIME]    <= INV_W'(INIT_DIME);
      r_inv[COIN_QUARTER] <= INV_W'(INIT_QUARTER);
      r_inv[COIN_DOLLAR]  <= INV_W'(INIT_DOLLAR);
    end else begin
      r_inv <= w_inv_nxt;
    end
  end

  assign o_inv = r_inv;

endmodule

// File: rtl/vend_change_dispenser.sv
// Change dispenser: pays a requested amount one coin at a time, largest
// coin first, falling back to smaller coins when a tube is empty.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | ready for a request; latches amount on i_req_valid
//   ST_SELECT | one cycle: pick largest coin <= remaining with stock
//   ST_EJECT  | o_eject_valid high until ack or ack timeout
//   ST_FINISH | one-cycle o_done pulse; results held until next accept
//
// Ports: request handshake (i_req_*, o_req_ready), hopper handshake
// (o_eject_*, i_eject_ack), refill (i_refill_*), transaction results
// (o_done, o_fault, o_shortfall, o_disp_*) and live inventory (o_inv_*).
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W        = 8,
  parameter int INV_W        = 6,
  parameter int INIT_NICKEL  = 20,
  parameter int INIT_DIME    = 20,
  parameter int INIT_QUARTER = 20,
  parameter int INIT_DOLLAR  = 4,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  input  logic [AMT_W-1:0] i_req_amount,
  output logic             o_req_ready,
  output logic             o_eject_valid,
  output logic [1:0]       o_eject_coin,
  input  logic             i_eject_ack,
  input  logic             i_refill_valid,
  input  logic [1:0]       i_refill_coin,
  input  logic [INV_W-1:0] i_refill_count,
  output logic             o_done,
  output logic             o_fault,
  output logic [AMT_W-1:0] o_shortfall,
  output logic [5:0]       o_disp_nickel,
  output logic [5:0]       o_disp_dime,
  output logic [5:0]       o_disp_quarter,
  output logic [5:0]       o_disp_dollar,
  output logic [INV_W-1:0] o_inv_nickel,
  output logic [INV_W-1:0] o_inv_dime,
  output logic [INV_W-1:0] o_inv_quarter,
  output logic [INV_W-1:0] o_inv_dollar
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  state_e                r_state, w_state_nxt;
  logic [AMT_W-1:0]      r_rem;
  logic [1:0]            r_coin;
  logic [TMR_W-1:0]      r_tmr;
  logic                  r_fault;
  logic [AMT_W-1:0]      r_shortfall;
  logic [3:0][5:0]       r_disp;
  logic [3:0][INV_W-1:0] w_inv;
  logic [3:0]            w_nonzero;
  logic [3:0][AMT_W-1:0] w_val;
  logic                  w_found;
  logic [1:0]            w_pick;
  logic                  w_ack;

  assign w_ack = (r_state == ST_EJECT) && i_eject_ack;

  vend_coin_inventory #(
    .INV_W(INV_W), .INIT_NICKEL(INIT_NICKEL), .INIT_DIME(INIT_DIME),
    .INIT_QUARTER(INIT_QUARTER), .INIT_DOLLAR(INIT_DOLLAR)
  ) u_inv (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_refill_valid(i_refill_valid), .i_refill_coin(i_refill_coin),
    .i_refill_count(i_refill_count),
    .i_dec_valid(w_ack), .i_dec_coin(r_coin),
    .o_inv(w_inv), .o_nonzero(w_nonzero)
  );

  // Ascending scan: the last fitting coin wins, i.e. the largest one.
  always_comb begin
    w_val   = '0;
    w_found = 1'b0;
    w_pick  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_val[i] = AMT_W'(coin_value(2'(i)));
      if (w_nonzero[i] && (w_val[i] <= r_rem)) begin
        w_found = 1'b1;
        w_pick  = 2'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_req_valid) w_state_nxt = ST_SELECT;
      ST_SELECT: w_state_nxt = w_found ? ST_EJECT : ST_FINISH;
      ST_EJECT: begin
        if (i_eject_ack)        w_state_nxt = ST_SELECT;
        else if (r_tmr == '0)   w_state_nxt = ST_FINISH;
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Timer is a down-counter loaded on each entry to EJECT; reaching zero
  // without an ack ends the transaction with the current coin unpaid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem       <= '0;
      r_coin      <= 2'd0;
      r_tmr       <= '0;
      r_fault     <= 1'b0;
      r_shortfall <= '0;
      r_disp      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_req_valid) begin
          r_rem       <= i_req_amount;
          r_disp      <= '0;
          r_fault     <= 1'b0;
          r_shortfall <= '0;
        end
        ST_SELECT: begin
          if (w_found) begin
            r_coin <= w_pick;
            r_tmr  <= TMR_W'(ACK_TIMEOUT - 1);
          end else begin
            r_shortfall <= r_rem;
          end
        end
        ST_EJECT: begin
          if (i_eject_ack) begin
            r_rem          <= r_rem - w_val[r_coin];
            r_disp[r_coin] <= r_disp[r_coin] + 6'd1;
          end else if (r_tmr == '0) begin
            r_fault     <= 1'b1;
            r_shortfall <= r_rem;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready    = (r_state == ST_IDLE);
  assign o_eject_valid  = (r_state == ST_EJECT);
  assign o_done         = (r_state == ST_FINISH);
  assign o_eject_coin   = r_coin;
  assign o_fault        = r_fault;
  assign o_shortfall    = r_shortfall;
  assign o_disp_nickel  = r_disp[COIN_NICKEL];
  assign o_disp_dime    = r_disp[COIN_DIME];
  assign o_disp_quarter = r_disp[COIN_QUARTER];
  assign o_disp_dollar  = r_disp[COIN_DOLLAR];
  assign o_inv_nickel   = w_inv[COIN_NICKEL];
  assign o_inv_dime     = w_inv[COIN_DIME];
  assign o_inv_quarter  = w_inv[COIN_QUARTER];
  assign o_inv_dollar   = w_inv[COIN_DOLLAR];

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Bench for vend_change_dispenser: a greedy change model with per-coin
// inventory predicts every eject, the final results and the inventory.
module tb_vend_change_dispenser;

  localparam int AMT_W = 8;
  localparam int INV_W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             req_valid, eject_ack, refill_valid;
  logic [AMT_W-1:0] req_amount;
  logic [1:0]       refill_coin;
  logic [INV_W-1:0] refill_count;
  logic             req_ready, eject_valid, done, fault;
  logic [1:0]       eject_coin;
  logic [AMT_W-1:0] shortfall;
  logic [5:0]       disp_n, disp_d, disp_q, disp_l;
  logic [INV_W-1:0] inv_n, inv_d, inv_q, inv_l;

  logic             q_req_valid, q_eject_ack, q_refill_valid;
  logic [AMT_W-1:0] q_req_amount;
  logic [1:0]       q_refill_coin;
  logic [INV_W-1:0] q_refill_count;
  logic             q_req_ready, q_eject_valid, q_done, q_fault;
  logic [1:0]       q_eject_coin;
  logic [AMT_W-1:0] q_shortfall;
  logic [5:0]       q_disp_n, q_disp_d, q_disp_q, q_disp_l;
  logic [INV_W-1:0] q_inv_n, q_inv_d, q_inv_q, q_inv_l;

  vend_change_dispenser dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_amount(req_amount), .o_req_ready(req_ready),
    .o_eject_valid(eject_valid), .o_eject_coin(eject_coin), .i_eject_ack(eject_ack),
    .i_refill_valid(refill_valid), .i_refill_coin(refill_coin), .i_refill_count(refill_count),
    .o_done(done), .o_fault(fault), .o_shortfall(shortfall),
    .o_disp_nickel(disp_n), .o_disp_dime(disp_d), .o_disp_quarter(disp_q), .o_disp_dollar(disp_l),
    .o_inv_nickel(inv_n), .o_inv_dime(inv_d), .o_inv_quarter(inv_q), .o_inv_dollar(inv_l)
  );

  vend_change_dispenser #(.INIT_QUARTER(0)) dut_q0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(q_req_valid), .i_req_amount(q_req_amount), .o_req_ready(q_req_ready),
    .o_eject_valid(q_eject_valid), .o_eject_coin(q_eject_coin), .i_eject_ack(q_eject_ack),
    .i_refill_valid(q_refill_valid), .i_refill_coin(q_refill_coin), .i_refill_count(q_refill_count),
    .o_done(q_done), .o_fault(q_fault), .o_shortfall(q_shortfall),
    .o_disp_nickel(q_disp_n), .o_disp_dime(q_disp_d), .o_disp_quarter(q_disp_q), .o_disp_dollar(q_disp_l),
    .o_inv_nickel(q_inv_n), .o_inv_dime(q_inv_d), .o_inv_quarter(q_inv_q), .o_inv_dollar(q_inv_l)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int inv_m[4];
  int init_m[4] = '{20, 20, 20, 4};
  int val_m[4]  = '{5, 10, 25, 100};

  function automatic int dut_inv(input int i);
    case (i)
      0: return int'(inv_n);
      1: return int'(inv_d);
      2: return int'(inv_q);
      default: return int'(inv_l);
    endcase
  endfunction

  function automatic int dut_disp(input int i);
    case (i)
      0: return int'(disp_n);
      1: return int'(disp_d);
      2: return int'(disp_q);
      default: return int'(disp_l);
    endcase
  endfunction

  // Greedy rule: biggest coin not exceeding the remainder that is in stock.
  function automatic int pick(input int rem);
    for (int d = 3; d >= 0; d--)
      if (val_m[d] <= rem && inv_m[d] > 0) return d;
    return -1;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 63) ? 63 : a + b;
  endfunction

  task automatic do_refill(input int c, input int cnt);
    refill_valid = 1'b1; refill_coin = 2'(c); refill_count = 6'(cnt);
    @(posedge clk); #1;
    refill_valid = 1'b0;
    inv_m[c] = sat_add(inv_m[c], cnt);
    n_checks++;
    if (dut_inv(c) !== inv_m[c])
      $display("FAIL refill coin%0d: got %0d want %0d", c, dut_inv(c), inv_m[c]);
    else n_pass++;
  endtask

  // One full transaction from IDLE; optional refill applied on every ack cycle.
  task automatic run_txn(input int amt, input int max_lat, input bit rf_en,
                         input int rf_coin, input int rf_cnt);
    int rem;
    int d;
    int lat;
    int disp_m[4];
    rem = amt;
    disp_m = '{0, 0, 0, 0};
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL txn%0d ready: got %b want 1", amt, req_ready);
    else n_pass++;
    req_valid = 1'b1; req_amount = amt[AMT_W-1:0];
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0 || eject_valid !== 1'b0)
      $display("FAIL txn%0d select: ready %b valid %b want 0 0", amt, req_ready, eject_valid);
    else n_pass++;
    for (int step = 0; step < 80; step++) begin
      d = pick(rem);
      @(posedge clk); #1;
      if (d < 0) begin
        n_checks++;
        if (done !== 1'b1 || eject_valid !== 1'b0)
          $display("FAIL txn%0d done: done %b valid %b want 1 0", amt, done, eject_valid);
        else n_pass++;
        break;
      end
      n_checks++;
      if (eject_valid !== 1'b1 || eject_coin !== 2'(d))
        $display("FAIL txn%0d eject: valid %b coin %0d want 1 %0d", amt, eject_valid, eject_coin, d);
      else n_pass++;
      lat = $urandom_range(max_lat, 0);
      repeat (lat) begin @(posedge clk); #1; end
      if (lat > 0) begin
        n_checks++;
        if (eject_valid !== 1'b1 || eject_coin !== 2'(d))
          $display("FAIL txn%0d hold: valid %b coin %0d want 1 %0d", amt, eject_valid, eject_coin, d);
        else n_pass++;
      end
      eject_ack = 1'b1;
      if (rf_en) begin
        refill_valid = 1'b1; refill_coin = 2'(rf_coin); refill_count = 6'(rf_cnt);
      end
      @(posedge clk); #1;
      eject_ack = 1'b0; refill_valid = 1'b0;
      rem = rem - val_m[d];
      disp_m[d]++;
      inv_m[d]--;
      if (rf_en) inv_m[rf_coin] = sat_add(inv_m[rf_coin], rf_cnt);
    end
    n_checks++;
    if (shortfall !== AMT_W'(rem) || fault !== 1'b0)
      $display("FAIL txn%0d result: shortfall %0d fault %b want %0d 0", amt, shortfall, fault, rem);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (dut_disp(c) !== disp_m[c] || dut_inv(c) !== inv_m[c])
        $display("FAIL txn%0d coin%0d: disp %0d inv %0d want %0d %0d",
                 amt, c, dut_disp(c), dut_inv(c), disp_m[c], inv_m[c]);
      else n_pass++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL txn%0d idle: done %b ready %b want 0 1", amt, done, req_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (req_ready !== 1'b1 || eject_valid !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || shortfall !== '0)
      $display("FAIL reset ctl: ready %b valid %b done %b fault %b short %0d want 1 0 0 0 0",
               req_ready, eject_valid, done, fault, shortfall);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (dut_disp(c) !== 0 || dut_inv(c) !== init_m[c])
        $display("FAIL reset coin%0d: disp %0d inv %0d want 0 %0d", c, dut_disp(c), dut_inv(c), init_m[c]);
      else n_pass++;
    end
    #10 rst_n = 1'b1;
    inv_m = init_m;
    @(posedge clk); #1;
  endtask

  task automatic test_greedy();
    run_txn(65, 1, 1'b0, 0, 0);
  endtask

  task automatic test_residue();
    run_txn(7, 2, 1'b0, 0, 0);
    run_txn(0, 0, 1'b0, 0, 0);
    run_txn(3, 0, 1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    int n;
    bit stable;
    req_valid = 1'b1; req_amount = 8'd100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n = 0; stable = 1'b1;
    while (eject_valid === 1'b1 && n < 40) begin
      n++;
      if (eject_coin !== 2'd3) stable = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++;
    if (n != 15 || !stable)
      $display("FAIL timeout eject: cycles %0d stable %b want 15 1", n, stable);
    else n_pass++;
    n_checks++;
    if (done !== 1'b1 || fault !== 1'b1 || shortfall !== 8'd100 || inv_l !== 6'(inv_m[3]))
      $display("FAIL timeout result: done %b fault %b short %0d invl %0d want 1 1 100 %0d",
               done, fault, shortfall, inv_l, inv_m[3]);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || fault !== 1'b1 || shortfall !== 8'd100)
      $display("FAIL timeout hold: done %b fault %b short %0d want 0 1 100", done, fault, shortfall);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    req_valid = 1'b1; req_amount = 8'd40;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 10 && seen < 2; k++) begin
      @(posedge clk); #1;
      if (eject_valid === 1'b1) begin
        seen++;
        if (seen == 1) begin
          eject_ack = 1'b1;
          @(posedge clk); #1;
          eject_ack = 1'b0;
        end
      end
    end
    n_checks++;
    if (seen != 2) $display("FAIL rstmid second eject: seen %0d want 2", seen);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (eject_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rstmid async: valid %b ready %b want 0 1", eject_valid, req_ready);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (dut_inv(c) !== init_m[c])
        $display("FAIL rstmid inv%0d: got %0d want %0d", c, dut_inv(c), init_m[c]);
      else n_pass++;
    end
    #2 rst_n = 1'b1;
    inv_m = init_m;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1 || eject_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid release: ready %b valid %b done %b want 1 0 0", req_ready, eject_valid, done);
    else n_pass++;
  endtask

  task automatic test_saturate();
    do_refill(1, 62 - inv_m[1]);
    run_txn(10, 0, 1'b1, 1, 5);
    n_checks++;
    if (inv_d !== 6'd63) $display("FAIL sat dime: got %0d want 63", inv_d);
    else n_pass++;
    do_refill(1, 0);
  endtask

  task automatic test_no_quarters();
    q_req_valid = 1'b1; q_req_amount = 8'd30;
    @(posedge clk); #1;
    q_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (q_eject_valid !== 1'b1 || q_eject_coin !== 2'd1)
        $display("FAIL noq eject%0d: valid %b coin %0d want 1 1", k, q_eject_valid, q_eject_coin);
      else n_pass++;
      q_eject_ack = 1'b1;
      @(posedge clk); #1;
      q_eject_ack = 1'b0;
    end
    @(posedge clk); #1;
    n_checks++;
    if (q_done !== 1'b1 || q_disp_d !== 6'd3 || q_inv_d !== 6'd17 || q_inv_q !== 6'd0 || q_shortfall !== 8'd0)
      $display("FAIL noq result: done %b dispd %0d invd %0d invq %0d short %0d want 1 3 17 0 0",
               q_done, q_disp_d, q_inv_d, q_inv_q, q_shortfall);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(9, 0) < 3) do_refill($urandom_range(3, 0), $urandom_range(20, 0));
      run_txn($urandom_range(255, 0), $urandom_range(4, 0), 1'b0, 0, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_amount = '0; eject_ack = 1'b0;
    refill_valid = 1'b0; refill_coin = '0; refill_count = '0;
    q_req_valid = 1'b0; q_req_amount = '0; q_eject_ack = 1'b0;
    q_refill_valid = 1'b0; q_refill_coin = '0; q_refill_count = '0;
    inv_m = init_m;
    test_reset();
    test_greedy();
    test_residue();
    test_timeout();
    test_reset_mid();
    test_saturate();
    test_no_quarters();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
- Sequencer that pays out a change amount one coin at a time.
- Sits between the vending FSM and the physical coin hopper.
- Accepts a change request in cents and ejects coins greedily, largest first, using a valid/ack handshake per coin.
- Tracks hopper inventory per denomination, falls back to smaller coins when a tube is empty, and reports any unpaid residue.

Parameters:
- AMT_W, 8, width of amounts in cents.
- INV_W, 6, width of each inventory counter; saturates at 2^INV_W-1.
- INIT_NICKEL, 20, nickel inventory after reset.
- INIT_DIME, 20, dime inventory after reset.
- INIT_QUARTER, 20, quarter inventory after reset.
- INIT_DOLLAR, 4, dollar-coin inventory after reset.
- ACK_TIMEOUT, 15, maximum cycles to wait for eject_ack before faulting.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  change request present.
- req_amount  in  AMT_W  change owed, in cents.
- req_ready  out  1  high only in IDLE.
- eject_valid  out  1  coin eject command to hopper.
- eject_coin  out  2  coin code: 00 nickel, 01 dime, 10 quarter, 11 dollar.
- eject_ack  in  1  hopper confirms coin released.
- refill_valid  in  1  add coins to inventory.
- refill_coin  in  2  denomination being refilled.
- refill_count  in  INV_W  number of coins added.
- done  out  1  one-cycle pulse at end of transaction.
- fault  out  1  ack timeout in last transaction; held until next accept.
- shortfall  out  AMT_W  cents not paid in last transaction.
- disp_nickel, disp_dime, disp_quarter, disp_dollar  out  6 each  coins paid in last transaction.
- inv_nickel, inv_dime, inv_quarter, inv_dollar  out  INV_W each  current inventory.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; eject_valid=0, done=0, fault=0, shortfall=0.
  - All disp_* = 0.
  - inv_* = INIT_* values.
  - rem (internal remaining amount) = 0.
- States: IDLE, SELECT, EJECT, FINISH.
- IDLE:
  - req_ready=1.
  - On req_valid: latch rem=req_amount; clear disp_*, fault, shortfall; go to SELECT.
- SELECT (one cycle, eject_valid=0):
  - Choose the largest coin d such that value(d) <= rem and inv[d] > 0. Values are 5/10/25/100.
  - If such a coin exists: register eject_coin=d and go to EJECT.
  - Otherwise go to FINISH with shortfall=rem.
- EJECT:
  - eject_valid=1; eject_coin stays stable until ack.
  - On eject_ack=1 sampled: rem -= value(d), inv[d] -= 1, disp[d] += 1; return to SELECT.
  - If ACK_TIMEOUT cycles elapse with no ack: set fault=1, shortfall=rem (current coin not deducted), go to FINISH.
  - The timeout counter resets on every entry to EJECT.
- FINISH:
  - done=1 for exactly one cycle; go to IDLE.
  - shortfall, fault and disp_* hold until the next accept.
- Latency:
  - Accept on edge k gives first eject_valid after edge k+1.
  - Per coin: one SELECT cycle plus ack wait.
  - done follows the final SELECT by one cycle.
- Zero amount, or amount below 5: no eject; done two cycles after accept; shortfall = amount (0..4).
- Residue: amounts that are not multiples of 5 end with shortfall = residue (1..4). An empty inventory can leave a larger shortfall.
- req_valid outside IDLE is ignored; the requester must hold req_valid until it sees req_ready.
- Refill:
  - Accepted in every state: inv[refill_coin] += refill_count, saturating at max.
  - Refill and decrement of the same coin in the same cycle: result = inv - 1 + count, then saturate.
  - A refill during SELECT takes effect in the next SELECT.
- eject_ack outside EJECT is ignored.
- Arithmetic: rem never underflows, because selection guarantees value <= rem. disp_* are 6 bits, so the maximum of 51 nickels fits.
- Reset mid-transaction:
  - Transaction is abandoned; eject_valid drops asynchronously.
  - Inventory reloads INIT_*; coins already ejected are not recounted.

Decomposition:
- Shared package vend_pkg:
  - coin code type: NICKEL=0, DIME=1, QUARTER=2, DOLLAR=3.
  - coin value constants 5/10/25/100.
  - state enumeration.
- Sub-module vend_coin_inventory:
  - four INV_W saturating counters with reset init, refill add and single-coin decrement.
  - exposes an inv_* vector and per-coin nonzero flags to the selector.

Test Plan:
1. Default inventory, req 65, ack 1 cycle after each eject_valid → coin sequence Q,Q,D,N; disp_quarter=2, disp_dime=1, disp_nickel=1; shortfall=0; inv_quarter=18; single done pulse.
2. INIT_QUARTER=0, req 30 → D,D,D; disp_dime=3; inv_dime=17.
3. req 7 → one N; shortfall=2. req 0 → no eject; done two cycles after accept; shortfall=0.
4. req 100, eject_ack held 0 → eject_coin=11 held for 15 cycles; then fault=1, shortfall=100, inv_dollar=4.
5. inv_dime=62 with refill_coin=DIME, refill_count=5 in the same cycle as a dime ack → inv_dime=63 (saturated). Next refill of 0 → inv_dime unchanged.
6. req 40, assert rst_n=0 during the second EJECT → eject_valid=0 immediately; all inv_* back to INIT_*; req_ready=1 after release.
